pipe_stage_chain: RTL and testbench
===================================

// Module: pipe_stage_chain
// PURPOSE
//  Parametrised elastic chain of pipeline registers for the pipelined CPU.
//  Carries a WIDTH-bit packed stage payload through DEPTH stages using per-stage valid/ready backpressure.
//  Supports per-stage flush for branch/exception kill. Gaps between entries collapse, so bubbles do not cost stall cycles.
//  Exposes per-stage valid/data for hazard and forwarding checks. Replaces hand-written fixed stage registers.
// PARAMETERS
//  WIDTH  32  payload bits per stage
//  DEPTH  5   number of register stages (>=1)
//  CNT_W  32  perf counter width
// PORTS
//  clk          in   1              rising-edge clock
//  rst          in   1              asynchronous, active-high reset
//  in_valid     in   1              upstream entry present
//  in_ready     out  1              chain accepts entry this cycle
//  in_data      in   WIDTH          upstream payload
//  out_valid    out  1              oldest entry present at stage DEPTH-1
//  out_ready    in   1              downstream consumes this cycle
//  out_data     out  WIDTH          payload of stage DEPTH-1
//  flush        in   DEPTH          bit i kills stage i this cycle
//  stage_valid  out  DEPTH          registered valid of every stage
//  stage_data   out  DEPTH*WIDTH    registered payload; stage i is at [i*WIDTH +: WIDTH]
//  occ          out  $clog2(DEPTH+1) registered count of valid stages
//  stall_cnt    out  CNT_W          cycles with out_valid && !out_ready (perf)
//  kill_cnt     out  CNT_W          valid entries removed by flush (perf)
// BEHAVIOUR
//  - Reset (async, rst=1): all valid=0, data=0, occ=0, counters=0; out_valid=0; in_ready=1.
//  - Transfer rule, stage i to i+1: occurs when v[i] && !flush[i] && rdy[i+1].
//  - rdy[i] = !v[i] || flush[i] || mv[i], where mv[i] means stage i moves to i+1 this cycle.
//  - Last stage: mv[D-1] = v[D-1] && !flush[D-1] && out_ready. in_ready = rdy[0].
//  - Ready is combinational from out_ready back to in_ready. No skid; one entry per stage max.
//  - out_valid = v[D-1] && !flush[D-1]. out_data = data[D-1].
//  - Flush[i]: v[i] is 0 after the edge.
//      Stage i's entry never moves to i+1.
//      Any entry moving into stage i this cycle is accepted upstream and discarded.
//  - Flush[0] with in_valid=1: in_ready=1 and the input is dropped.
//  - Latency: handshake in cycle t gives out_valid in cycle t+DEPTH when unstalled. Throughput is 1/cycle.
//  - Full chain with out_ready=0: in_ready=0. Order is strictly FIFO.
//  - Bubble collapse: an invalid stage i accepts from i-1 regardless of downstream stall.
//  - Data registers load only on transfer; otherwise they hold. Stale data under v=0 is don't-care.
//  - occ_next = popcount(v_next). occ never exceeds DEPTH.
//  - Simultaneous push, pop and flush resolve in one edge per the rules above. No priority beyond flush > move.
//  - Reset asserted mid-stream discards all entries immediately (async). First accept is on the edge after deassert.
// CONFIGURATION
//  - Macro PIPE_CHAIN_PERF_EN:
//      Defined: stall_cnt += 1 per stall cycle; kill_cnt += popcount(v & flush) per cycle.
//      Both saturate at 2^CNT_W-1 and reset to 0.
//  - Undefined: stall_cnt and kill_cnt are tied to 0 and no counter flops are built. Ports remain present.
// STRUCTURE
//  - Package pipe_chain_pkg:
//      occ_w(DEPTH) function = $clog2(DEPTH+1).
//      Saturating-add function.
//      Default WIDTH/DEPTH constants for CPU stages.
//  - Sub-module pipe_stage_slot: one valid+data register with load/flush/ready logic.
//      The top instantiates DEPTH slots in a generate loop and adds occ and the perf counters.
// TESTING
//  1. Reset: rst pulse while in_valid=1 -> occ=0, out_valid=0, in_ready=1, stage_valid=0.
//  2. Stream (DEPTH=5), out_ready=1:
//      Push 0x11..0x15 on consecutive cycles -> out_data 0x11 valid 5 cycles after first handshake.
//      Then 0x12..0x15 on back-to-back cycles.
//  3. Backpressure, out_ready=0, push 7 entries:
//      5 accepted, then in_ready=0, occ=5, stall_cnt counting.
//      Raise out_ready -> drains 5 in order and in_ready returns 1 the same cycle.
//  4. Bubble collapse: out_ready=0, only stages 4 and 0 valid -> next edge stage 0 entry moves to stage 1; occ stays 2.
//  5. Flush: chain full, flush=5'b00011, in_valid=1 ->
//      occ 5->3, input dropped, kill_cnt+=2 (perf build), remaining order preserved.
//  6. Async reset mid-drain: rst asserted between edges -> out_valid falls without clk; counters=0.

Source files
------------

// File: rtl/pipe_chain_pkg.sv
// Shared constants and helpers for the elastic pipeline register chain.
//   occ_w()   : width of an occupancy count for a given depth
//   sat_add() : unsigned add clamped to 2^w-1 (w <= 64)
package pipe_chain_pkg;

    // Default geometry for the CPU stage payload chain.
    localparam int unsigned CPU_STAGE_WIDTH = 32;
    localparam int unsigned CPU_STAGE_DEPTH = 5;
    localparam int unsigned CPU_PERF_CNT_W  = 32;

    // Bits needed to count 0..depth valid stages.
    function automatic int unsigned occ_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Saturating add; result clamps at the all-ones value of a w-bit counter.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned w);
        logic [64:0] sum;
        logic [64:0] max_v;
        sum   = {1'b0, a} + {1'b0, b};
        max_v = (65'd1 << w) - 65'd1;
        if (sum > max_v) begin
            return max_v[63:0];
        end
        return sum[63:0];
    endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One stage of the elastic chain: a valid bit plus payload register.
// Ports:
//   clk, rst        clock, async active-high reset
//   up_valid_i      entry offered by the previous stage (or chain input)
//   up_data_i       payload offered by the previous stage
//   flush_i         kill this stage this cycle
//   down_ready_i    next stage (or chain output) can take our entry
//   valid_o/data_o  registered valid and payload
//   ready_c_o       stage can accept an entry this cycle (combinational)
//   offer_c_o       stage offers a live (unflushed) entry downstream (combinational)
//   valid_nxt_c_o   valid value after the coming edge (combinational)
module pipe_stage_slot #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid_i,
    input  logic [WIDTH-1:0] up_data_i,
    input  logic             flush_i,
    input  logic             down_ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             ready_c_o,
    output logic             offer_c_o,
    output logic             valid_nxt_c_o
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             move;
    logic             load;

    // Handshake and next-state: flush beats both hold and load, and a
    // flushed stage still accepts (then discards) whatever moves in.
    always_comb begin
        offer_c_o = valid_q && !flush_i;
        move      = offer_c_o && down_ready_i;
        ready_c_o = !valid_q || flush_i || move;
        load      = up_valid_i && ready_c_o;
        valid_d   = !flush_i && (load || (valid_q && !move));
        data_d    = load ? up_data_i : data_q;
        valid_nxt_c_o = valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// Elastic chain of DEPTH pipeline registers with valid/ready backpressure,
// per-stage flush, bubble collapse and per-stage visibility for hazard logic.
// Ports:
//   clk, rst                clock, async active-high reset
//   in_valid/in_ready/in_data     upstream handshake
//   out_valid/out_ready/out_data  downstream handshake (stage DEPTH-1)
//   flush[i]                kill stage i this cycle
//   stage_valid/stage_data  registered per-stage valid and payload
//   occ                     registered count of valid stages
//   stall_cnt/kill_cnt      perf counters
// Build option: define PIPE_CHAIN_PERF_EN to build the saturating perf
// counters; otherwise they read as zero and no counter flops exist.
module pipe_stage_chain
    import pipe_chain_pkg::*;
#(
    parameter int unsigned WIDTH = CPU_STAGE_WIDTH,
    parameter int unsigned DEPTH = CPU_STAGE_DEPTH,
    parameter int unsigned CNT_W = CPU_PERF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    input  logic [DEPTH-1:0]         flush,
    output logic [DEPTH-1:0]         stage_valid,
    output logic [DEPTH*WIDTH-1:0]   stage_data,
    output logic [occ_w(DEPTH)-1:0]  occ,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         kill_cnt
);

    localparam int unsigned OCC_W = occ_w(DEPTH);

    logic [DEPTH-1:0]            v_q;
    logic [DEPTH-1:0]            offer;
    logic [DEPTH-1:0]            v_nxt;
    logic [DEPTH-1:0][WIDTH-1:0] d_q;
    logic [OCC_W-1:0]            occ_q;
    logic [OCC_W-1:0]            occ_d;

    // Slot chain; ready ripples combinationally from out_ready back to in_ready.
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic             up_valid;
        logic [WIDTH-1:0] up_data;
        logic             dn_ready;
        logic             rdy_c;

        if (i == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = in_data;
        end else begin : g_body
            assign up_valid = offer[i-1];
            assign up_data  = d_q[i-1];
        end

        if (i == DEPTH - 1) begin : g_tail
            assign dn_ready = out_ready;
        end else begin : g_link
            assign dn_ready = g_slot[i+1].rdy_c;
        end

        pipe_stage_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk          (clk),
            .rst          (rst),
            .up_valid_i   (up_valid),
            .up_data_i    (up_data),
            .flush_i      (flush[i]),
            .down_ready_i (dn_ready),
            .valid_o      (v_q[i]),
            .data_o       (d_q[i]),
            .ready_c_o    (rdy_c),
            .offer_c_o    (offer[i]),
            .valid_nxt_c_o(v_nxt[i])
        );

        assign stage_data[i*WIDTH +: WIDTH] = d_q[i];
    end

    assign in_ready    = g_slot[0].rdy_c;
    assign out_valid   = offer[DEPTH-1];
    assign out_data    = d_q[DEPTH-1];
    assign stage_valid = v_q;

    // Occupancy tracks the post-edge valid vector so it stays registered.
    always_comb begin
        occ_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ_d = occ_d + OCC_W'(v_nxt[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occ = occ_q;

`ifdef PIPE_CHAIN_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] kill_cnt_q;
    logic [CNT_W-1:0] kill_cnt_d;
    logic [OCC_W-1:0] kill_inc;

    // Stall: live output not taken. Kill: valid entries hit by flush.
    always_comb begin
        kill_inc = '0;
        for (int k = 0; k < DEPTH; k++) begin
            kill_inc = kill_inc + OCC_W'(v_q[k] & flush[k]);
        end
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready) begin
            stall_cnt_d = CNT_W'(sat_add(64'(stall_cnt_q), 64'd1, CNT_W));
        end
        kill_cnt_d = CNT_W'(sat_add(64'(kill_cnt_q), 64'(kill_inc), CNT_W));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            kill_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign kill_cnt  = kill_cnt_q;
`else
    assign stall_cnt = '0;
    assign kill_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a slot-array model.
module tb_pipe_stage_chain;

    localparam int unsigned W  = 32;
    localparam int unsigned D  = 5;
    localparam int unsigned CW = 32;
    localparam int unsigned OW = $clog2(D + 1);
`ifdef PIPE_CHAIN_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [D-1:0]   flush;
    logic [D-1:0]   stage_valid;
    logic [D*W-1:0] stage_data;
    logic [OW-1:0]  occ;
    logic [CW-1:0]  stall_cnt;
    logic [CW-1:0]  kill_cnt;

    pipe_stage_chain #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .flush      (flush),
        .stage_valid(stage_valid),
        .stage_data (stage_data),
        .occ        (occ),
        .stall_cnt  (stall_cnt),
        .kill_cnt   (kill_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    bit          chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: what sits in each stage, plus the perf tallies.
    logic         m_v [D] = '{default: 1'b0};
    logic [W-1:0] m_d [D] = '{default: '0};
    logic [CW-1:0] m_stall = '0;
    logic [CW-1:0] m_kill  = '0;

    // Which stages hand their entry on (leave) and which can take one (take).
    function automatic void model_flow(output logic [D-1:0] leave, output logic [D-1:0] take);
        logic go;
        leave = '0;
        take  = '0;
        for (int i = D - 1; i >= 0; i--) begin
            if (i == D - 1) go = out_ready;
            else            go = take[i+1];
            leave[i] = m_v[i] && !flush[i] && go;
            take[i]  = !m_v[i] || flush[i] || leave[i];
        end
    endfunction

    function automatic int model_occ();
        int n = 0;
        for (int i = 0; i < D; i++) n += int'(m_v[i]);
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [D-1:0] lv, tk;
        logic         nv [D];
        logic [W-1:0] nd [D];
        logic         src;
        longint       ksum;
        if (rst) begin
            for (int i = 0; i < D; i++) begin
                m_v[i] = 1'b0;
                m_d[i] = '0;
            end
            m_stall = '0;
            m_kill  = '0;
        end else begin
            model_flow(lv, tk);
            ksum = longint'(m_kill);
            for (int i = 0; i < D; i++) begin
                if (m_v[i] && flush[i]) ksum++;
            end
            if (PERF) begin
                if (m_v[D-1] && !flush[D-1] && !out_ready && m_stall != '1) m_stall = m_stall + 1'b1;
                m_kill = (ksum > longint'({CW{1'b1}})) ? '1 : CW'(ksum);
            end
            for (int i = 0; i < D; i++) begin
                if (i == 0) src = in_valid;
                else        src = m_v[i-1] && !flush[i-1];
                nd[i] = m_d[i];
                if (src && tk[i]) begin
                    if (i == 0) nd[i] = in_data;
                    else        nd[i] = m_d[i-1];
                end
                nv[i] = !flush[i] && ((src && tk[i]) || (m_v[i] && !lv[i]));
            end
            for (int i = 0; i < D; i++) begin
                m_v[i] = nv[i];
                m_d[i] = nd[i];
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [D-1:0] lv, tk;
        logic         ov;
        if (chk_en) begin
            model_flow(lv, tk);
            ov = m_v[D-1] && !flush[D-1];
            chk("in_ready", 64'(in_ready), 64'(tk[0]));
            chk("out_valid", 64'(out_valid), 64'(ov));
            if (ov) chk("out_data", 64'(out_data), 64'(m_d[D-1]));
            for (int i = 0; i < D; i++) begin
                chk("stage_valid", 64'(stage_valid[i]), 64'(m_v[i]));
                if (m_v[i]) chk("stage_data", 64'(stage_data[i*W +: W]), 64'(m_d[i]));
            end
            chk("occ", 64'(occ), 64'(model_occ()));
            chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
            chk("kill_cnt", 64'(kill_cnt), 64'(m_kill));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        bit hold_phase;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = '0;

        // Reset with input pending.
        #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hdead_beef;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_occ", 64'(occ), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_stage_valid", 64'(stage_valid), 64'd0);
        chk("rst_stall", 64'(stall_cnt), 64'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        chk_en   = 1'b1;
        cyc();

        // Streaming: five entries, first visible DEPTH cycles later.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        for (int k = 1; k <= 9; k++) begin
            cyc();
            if (k < 5) in_data = W'(32'h11 + k);
            else       in_valid = 1'b0;
            #1;
            if (k < 5) begin
                chk("stream_no_out", 64'(out_valid), 64'd0);
            end else begin
                chk("stream_out_valid", 64'(out_valid), 64'd1);
                chk("stream_out_data", 64'(out_data), 64'(32'h11 + k - 5));
            end
        end
        cyc();
        chk("stream_empty", 64'(occ), 64'd0);

        // Backpressure: seven offered, five fit.
        out_ready = 1'b0;
        acc = 0;
        for (int n = 0; n < 7; n++) begin
            in_valid = 1'b1;
            in_data  = W'(32'h21 + acc);
            #1;
            chk("bp_in_ready", 64'(in_ready), (n < 5) ? 64'd1 : 64'd0);
            if (in_ready) acc++;
            cyc();
        end
        chk("bp_accepts", 64'(acc), 64'd5);
        chk("bp_occ", 64'(occ), 64'd5);
        chk("bp_stall", 64'(stall_cnt), PERF ? 64'd2 : 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(in_ready), 64'd1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_drain_valid", 64'(out_valid), 64'd1);
            chk("bp_drain_data", 64'(out_data), 64'(32'h21 + k));
            cyc();
        end
        chk("bp_drained", 64'(out_valid), 64'd0);
        chk("bp_stall_hold", 64'(stall_cnt), PERF ? 64'd2 : 64'd0);

        // Bubble collapse: stages 4 and 0 occupied, output stalled.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h41;
        cyc();
        in_valid = 1'b0;
        repeat (3) cyc();
        in_valid = 1'b1;
        in_data  = 32'h42;
        cyc();
        in_valid = 1'b0;
        chk("bub_valid0", 64'(stage_valid), 64'b10001);
        chk("bub_s4", 64'(stage_data[4*W +: W]), 64'h41);
        chk("bub_s0", 64'(stage_data[0 +: W]), 64'h42);
        cyc();
        chk("bub_valid1", 64'(stage_valid), 64'b10010);
        chk("bub_occ", 64'(occ), 64'd2);
        chk("bub_model_occ", 64'(model_occ()), 64'd2);
        chk("bub_s1", 64'(stage_data[1*W +: W]), 64'h42);
        out_ready = 1'b1;
        repeat (4) cyc();
        chk("bub_empty", 64'(occ), 64'd0);

        // Flush of the two youngest stages while full, input dropped.
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = W'(32'h31 + k);
            cyc();
        end
        chk("fl_full", 64'(occ), 64'd5);
        chk("fl_kill0", 64'(kill_cnt), 64'd0);
        flush    = 5'b00011;
        in_valid = 1'b1;
        in_data  = 32'h99;
        #1;
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        cyc();
        flush    = '0;
        in_valid = 1'b0;
        chk("fl_occ", 64'(occ), 64'd3);
        chk("fl_valid", 64'(stage_valid), 64'b11100);
        chk("fl_kill", 64'(kill_cnt), PERF ? 64'd2 : 64'd0);
        chk("fl_s2", 64'(stage_data[2*W +: W]), 64'h33);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("fl_drain", 64'(out_data), 64'(32'h31 + k));
            cyc();
        end
        chk("fl_empty", 64'(occ), 64'd0);

        // Asynchronous reset mid-drain.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = W'(32'h61 + k);
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) cyc();
        chk("ar_pre_valid", 64'(out_valid), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_out_valid", 64'(out_valid), 64'd0);
        chk("ar_stage_valid", 64'(stage_valid), 64'd0);
        chk("ar_occ", 64'(occ), 64'd0);
        chk("ar_stall", 64'(stall_cnt), 64'd0);
        chk("ar_kill", 64'(kill_cnt), 64'd0);
        cyc();
        rst      = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h70;
        cyc();
        in_valid = 1'b0;
        chk("ar_first_accept", 64'(stage_valid[0]), 64'd1);
        chk("ar_first_data", 64'(stage_data[0 +: W]), 64'h70);
        repeat (6) cyc();

        // Randomized traffic with occasional long stalls and sparse flushes.
        hold_phase = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ((c % 150) == 0) hold_phase = ($urandom_range(0, 1) == 1);
            in_valid  = ($urandom_range(0, 99) < 65);
            in_data   = $urandom;
            out_ready = hold_phase ? ($urandom_range(0, 99) < 10) : ($urandom_range(0, 99) < 75);
            for (int i = 0; i < D; i++) flush[i] = ($urandom_range(0, 99) < 4);
            cyc();
        end
        flush     = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) cyc();
        chk("final_empty", 64'(occ), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
